// File: rtl/mux_pkg.sv
// Shared types and helpers for the N:1 scanning mux.
// State encoding and a select-width helper that never returns 0.
package mux_pkg;

  typedef enum logic {
    ST_IDLE,
    ST_SCAN
  } state_t;

  function automatic int clog2_min1(input int n);
    return (n < 3) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/mux_nx1_comb.sv
// Combinational N:1 W-bit select with out-of-range flag.
// Out-of-range selects return all zeros.
module mux_nx1_comb
  import mux_pkg::*;
#(
  parameter int N = 64,
  parameter int W = 1,
  localparam int SELW = clog2_min1(N)
) (
  input  logic [N*W-1:0]  a,
  input  logic [SELW-1:0] sel,
  output logic [W-1:0]    data,
  output logic            oob
);

  always_comb begin
    data = '0;
    oob  = (32'(sel) >= N);
    for (int i = 0; i < N; i++) begin
      if (32'(sel) == i) data = a[i*W +: W];
    end
  end

endmodule

// File: rtl/mux_nx1_scan.sv
// N:1 mux with registered output: manual select or full sweep.
// One FSM drives both the select source and the output registers.
module mux_nx1_scan
  import mux_pkg::*;
#(
  parameter int N = 64,
  parameter int W = 1,
  localparam int SELW = clog2_min1(N)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N*W-1:0]  a,
  input  logic [SELW-1:0] sel,
  input  logic            sel_vld,
  input  logic            scan_start,
  output logic [W-1:0]    y,
  output logic            y_vld,
  output logic [SELW-1:0] y_idx,
  output logic            sel_err,
  output logic            scan_last,
  output logic            busy
);

  localparam logic [SELW-1:0] LAST = SELW'(N - 1);

  state_t          state;
  logic [SELW-1:0] cnt;
  logic [SELW-1:0] pick;
  logic [W-1:0]    data;
  logic            oob;

  // The sweep counter owns the select while scanning.
  assign pick = (state == ST_SCAN) ? cnt : sel;

  mux_nx1_comb #(
    .N (N),
    .W (W)
  ) u_comb (
    .a    (a),
    .sel  (pick),
    .data (data),
    .oob  (oob)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      y         <= '0;
      y_vld     <= 1'b0;
      y_idx     <= '0;
      sel_err   <= 1'b0;
      scan_last <= 1'b0;
      busy      <= 1'b0;
    end else begin
      y_vld     <= 1'b0;
      sel_err   <= 1'b0;
      scan_last <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (scan_start) begin
            state <= ST_SCAN;
            cnt   <= '0;
            busy  <= 1'b1;
          end else if (sel_vld) begin
            y       <= data;
            y_idx   <= sel;
            y_vld   <= 1'b1;
            sel_err <= oob;
          end
        end
        ST_SCAN: begin
          y     <= data;
          y_idx <= cnt;
          y_vld <= 1'b1;
          if (cnt == LAST) begin
            scan_last <= 1'b1;
            state     <= ST_IDLE;
            cnt       <= '0;
            busy      <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mux_nx1_scan.sv
// Directed bench for mux_nx1_scan across four parameter sets.
// Shared controls; each instance checked in its own phase.
module tb_mux_nx1_scan;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       sel_vld;
  logic       scan_start;
  logic [7:0] sel;

  logic [63:0]  a64;
  logic [511:0] a64w;
  logic [191:0] a48;
  logic [63:0]  a16;

  logic [0:0] y64;
  logic       v64, e64, l64, b64;
  logic [5:0] i64;

  logic [7:0] yw;
  logic       vw, ew, lw, bw;
  logic [5:0] iw;

  logic [3:0] y48;
  logic       v48, e48, l48, b48;
  logic [5:0] i48;

  logic [3:0] y16;
  logic       v16, e16, l16, b16;
  logic [3:0] i16;

  mux_nx1_scan #(.N(64), .W(1)) d64 (
    .clk(clk), .rst(rst), .a(a64), .sel(sel[5:0]),
    .sel_vld(sel_vld), .scan_start(scan_start),
    .y(y64), .y_vld(v64), .y_idx(i64), .sel_err(e64),
    .scan_last(l64), .busy(b64)
  );

  mux_nx1_scan #(.N(64), .W(8)) dw (
    .clk(clk), .rst(rst), .a(a64w), .sel(sel[5:0]),
    .sel_vld(sel_vld), .scan_start(scan_start),
    .y(yw), .y_vld(vw), .y_idx(iw), .sel_err(ew),
    .scan_last(lw), .busy(bw)
  );

  mux_nx1_scan #(.N(48), .W(4)) d48 (
    .clk(clk), .rst(rst), .a(a48), .sel(sel[5:0]),
    .sel_vld(sel_vld), .scan_start(scan_start),
    .y(y48), .y_vld(v48), .y_idx(i48), .sel_err(e48),
    .scan_last(l48), .busy(b48)
  );

  mux_nx1_scan #(.N(16), .W(4)) d16 (
    .clk(clk), .rst(rst), .a(a16), .sel(sel[3:0]),
    .sel_vld(sel_vld), .scan_start(scan_start),
    .y(y16), .y_vld(v16), .y_idx(i16), .sel_err(e16),
    .scan_last(l16), .busy(b16)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [7:0] sel;
    logic       vld;
    logic       e64;
    logic [3:0] e48;
    logic [5:0] eidx;
    logic       eerr;
  } vec_t;

  vec_t tbl[12];

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    int nl;
    int s;
    logic exp;

    tbl[0]  = '{8'd2,  1'b1, 1'b1, 4'd6,  6'd2,  1'b0};
    tbl[1]  = '{8'd0,  1'b1, 1'b0, 4'd0,  6'd0,  1'b0};
    tbl[2]  = '{8'd5,  1'b1, 1'b1, 4'd15, 6'd5,  1'b0};
    tbl[3]  = '{8'd20, 1'b1, 1'b1, 4'd12, 6'd20, 1'b0};
    tbl[4]  = '{8'd7,  1'b0, 1'b1, 4'd12, 6'd20, 1'b0};
    tbl[5]  = '{8'd40, 1'b1, 1'b0, 4'd8,  6'd40, 1'b0};
    tbl[6]  = '{8'd47, 1'b1, 1'b0, 4'd13, 6'd47, 1'b0};
    tbl[7]  = '{8'd50, 1'b1, 1'b1, 4'd0,  6'd50, 1'b1};
    tbl[8]  = '{8'd63, 1'b1, 1'b1, 4'd0,  6'd63, 1'b1};
    tbl[9]  = '{8'd49, 1'b1, 1'b0, 4'd0,  6'd49, 1'b1};
    tbl[10] = '{8'd9,  1'b0, 1'b0, 4'd0,  6'd49, 1'b0};
    tbl[11] = '{8'd56, 1'b1, 1'b1, 4'd0,  6'd56, 1'b1};

    a64 = 64'hA5A5_0000_FFFF_1234;
    for (int i = 0; i < 64; i++) a64w[i*8 +: 8] = 8'(i) ^ 8'hC3;
    for (int i = 0; i < 48; i++) a48[i*4 +: 4] = 4'((i * 3) % 16);
    for (int i = 0; i < 16; i++) a16[i*4 +: 4] = 4'(15 - i);

    // reset held two cycles with a pending request
    rst = 1'b1;
    sel_vld = 1'b1;
    sel = 8'd2;
    scan_start = 1'b0;
    for (int c = 0; c < 2; c++) begin
      tick();
      chk("rst_y", 64'(y64), 64'd0);
      chk("rst_vld", 64'(v64), 64'd0);
      chk("rst_idx", 64'(i64), 64'd0);
      chk("rst_err", 64'(e64), 64'd0);
      chk("rst_last", 64'(l64), 64'd0);
      chk("rst_busy", 64'(b64), 64'd0);
    end
    rst = 1'b0;

    // manual requests, back to back, both widths at once
    for (int r = 0; r < 12; r++) begin
      sel = tbl[r].sel;
      sel_vld = tbl[r].vld;
      tick();
      chk($sformatf("m64_y[%0d]", r), 64'(y64), 64'(tbl[r].e64));
      chk($sformatf("m64_vld[%0d]", r), 64'(v64), 64'(tbl[r].vld));
      chk($sformatf("m64_idx[%0d]", r), 64'(i64), 64'(tbl[r].eidx));
      chk($sformatf("m64_err[%0d]", r), 64'(e64), 64'd0);
      chk($sformatf("m48_y[%0d]", r), 64'(y48), 64'(tbl[r].e48));
      chk($sformatf("m48_vld[%0d]", r), 64'(v48), 64'(tbl[r].vld));
      chk($sformatf("m48_idx[%0d]", r), 64'(i48), 64'(tbl[r].eidx));
      chk($sformatf("m48_err[%0d]", r), 64'(e48), 64'(tbl[r].eerr));
    end
    sel_vld = 1'b0;
    tick();
    chk("m48_vld_idle", 64'(v48), 64'd0);

    // scan_start beats a same-cycle manual request
    scan_start = 1'b1;
    sel_vld = 1'b1;
    sel = 8'd3;
    tick();
    scan_start = 1'b0;
    sel_vld = 1'b0;
    chk("sw_start_vld", 64'(vw), 64'd0);
    chk("sw_start_busy", 64'(bw), 64'd1);
    for (int i = 0; i < 64; i++) begin
      tick();
      chk($sformatf("sw_vld[%0d]", i), 64'(vw), 64'd1);
      chk($sformatf("sw_idx[%0d]", i), 64'(iw), 64'(i));
      chk($sformatf("sw_y[%0d]", i), 64'(yw), 64'(8'(i) ^ 8'hC3));
      chk($sformatf("sw_last[%0d]", i), 64'(lw), 64'(i == 63));
      chk($sformatf("sw_busy[%0d]", i), 64'(bw), 64'(i != 63));
    end
    tick();
    chk("sw_end_vld", 64'(vw), 64'd0);
    chk("sw_end_last", 64'(lw), 64'd0);
    chk("sw_end_busy", 64'(bw), 64'd0);

    // sweep with ignored mid-sweep and final-beat requests
    scan_start = 1'b1;
    tick();
    scan_start = 1'b0;
    nl = 0;
    for (int i = 0; i < 16; i++) begin
      tick();
      chk($sformatf("s16_idx[%0d]", i), 64'(i16), 64'(i));
      chk($sformatf("s16_y[%0d]", i), 64'(y16), 64'(15 - i));
      chk($sformatf("s16_vld[%0d]", i), 64'(v16), 64'd1);
      chk($sformatf("s16_last[%0d]", i), 64'(l16), 64'(i == 15));
      nl += int'(l16);
      if (i == 5) begin
        sel_vld = 1'b1;
        sel = 8'd2;
        scan_start = 1'b1;
      end
      if (i == 6) begin
        sel_vld = 1'b0;
        scan_start = 1'b0;
      end
      if (i == 14) scan_start = 1'b1;
      if (i == 15) scan_start = 1'b0;
    end
    chk("s16_one_last", 64'(nl), 64'd1);
    tick();
    chk("s16_end_vld", 64'(v16), 64'd0);
    chk("s16_end_busy", 64'(b16), 64'd0);
    tick();
    chk("s16_norestart_vld", 64'(v16), 64'd0);
    chk("s16_norestart_busy", 64'(b16), 64'd0);

    // reset aborts a sweep at index 9
    scan_start = 1'b1;
    tick();
    scan_start = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk($sformatf("r16_idx[%0d]", i), 64'(i16), 64'(i));
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("r16_y", 64'(y16), 64'd0);
    chk("r16_vld", 64'(v16), 64'd0);
    chk("r16_idx", 64'(i16), 64'd0);
    chk("r16_err", 64'(e16), 64'd0);
    chk("r16_last", 64'(l16), 64'd0);
    chk("r16_busy", 64'(b16), 64'd0);
    tick();
    tick();
    chk("r16_after_vld", 64'(v16), 64'd0);
    chk("r16_after_busy", 64'(b16), 64'd0);

    // random back-to-back requests with changing inputs
    sel_vld = 1'b1;
    for (int k = 0; k < 64; k++) begin
      s = int'($urandom_range(0, 63));
      sel = 8'(s);
      a64 = {$urandom, $urandom};
      exp = a64[s];
      tick();
      chk($sformatf("rnd_y[%0d]", k), 64'(y64), 64'(exp));
      chk($sformatf("rnd_vld[%0d]", k), 64'(v64), 64'd1);
      chk($sformatf("rnd_idx[%0d]", k), 64'(i64), 64'(s));
    end
    sel_vld = 1'b0;
    tick();
    chk("rnd_end_vld", 64'(v64), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
